painterengine_gpu_displayfetch: RTL

Per-frame scanout sequencer for the GPU display path. On each frame-start pulse it latches the display mode, texture size and base address, and clips the texture to the active display resolution. It then issues one line-read request per visible row to the downstream framebuffer line reader over a req/ack/done handshake. It sits between the video timing generator, which supplies frame start, and the memory read engine that feeds the display FIFO.

---
 rtl/painterengine_gpu_pkg.sv | 41 ++++
 rtl/painterengine_gpu_displayfetch_if.sv | 27 ++
 rtl/painterengine_gpu_displayclip.sv | 34 +++
 rtl/painterengine_gpu_displayfetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared GPU display definitions: display mode codes, per-mode resolution
// limits and the scanout sequencer state encoding.
package painterengine_gpu_pkg;

  localparam logic [2:0] MODE_1280X720  = 3'b000;
  localparam logic [2:0] MODE_480X272   = 3'b001;
  localparam logic [2:0] MODE_640X480   = 3'b010;
  localparam logic [2:0] MODE_800X480   = 3'b011;
  localparam logic [2:0] MODE_800X600   = 3'b100;
  localparam logic [2:0] MODE_1024X768  = 3'b101;
  localparam logic [2:0] MODE_1920X1080 = 3'b110;

  localparam logic [15:0] MODE0_W = 16'd1280;
  localparam logic [15:0] MODE0_H = 16'd720;
  localparam logic [15:0] MODE1_W = 16'd480;
  localparam logic [15:0] MODE1_H = 16'd272;
  localparam logic [15:0] MODE2_W = 16'd640;
  localparam logic [15:0] MODE2_H = 16'd480;
  localparam logic [15:0] MODE3_W = 16'd800;
  localparam logic [15:0] MODE3_H = 16'd480;
  localparam logic [15:0] MODE4_W = 16'd800;
  localparam logic [15:0] MODE4_H = 16'd600;
  localparam logic [15:0] MODE5_W = 16'd1024;
  localparam logic [15:0] MODE5_H = 16'd768;
  localparam logic [15:0] MODE6_W = 16'd1920;
  localparam logic [15:0] MODE6_H = 16'd1080;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_REQ,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } fetch_state_e;

  function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/painterengine_gpu_displayfetch_if.sv
// Line-read handshake between the scanout sequencer (master) and the
// framebuffer line reader (slave).
interface painterengine_gpu_displayfetch_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  line_req;
  logic                  line_ack;
  logic [ADDR_WIDTH-1:0] line_address;
  logic [15:0]           line_length;
  logic                  line_done;

  modport master (
    output line_req,
    output line_address,
    output line_length,
    input  line_ack,
    input  line_done
  );

  modport slave (
    input  line_req,
    input  line_address,
    input  line_length,
    output line_ack,
    output line_done
  );
endinterface

// File: rtl/painterengine_gpu_displayclip.sv
// Clips a texture size to the active resolution of the selected display
// mode; the invalid mode code yields a 0x0 clip.
module painterengine_gpu_displayclip
  import painterengine_gpu_pkg::*;
(
  input  logic [2:0]  i_wire_display_mode,
  input  logic [15:0] i_wire_image_width,
  input  logic [15:0] i_wire_image_height,
  output logic [15:0] o_wire_clip_width,
  output logic [15:0] o_wire_clip_height
);

  logic [15:0] lim_w;
  logic [15:0] lim_h;

  always_comb begin
    lim_w = '0;
    lim_h = '0;
    case (i_wire_display_mode)
      MODE_1280X720:  begin lim_w = MODE0_W; lim_h = MODE0_H; end
      MODE_480X272:   begin lim_w = MODE1_W; lim_h = MODE1_H; end
      MODE_640X480:   begin lim_w = MODE2_W; lim_h = MODE2_H; end
      MODE_800X480:   begin lim_w = MODE3_W; lim_h = MODE3_H; end
      MODE_800X600:   begin lim_w = MODE4_W; lim_h = MODE4_H; end
      MODE_1024X768:  begin lim_w = MODE5_W; lim_h = MODE5_H; end
      MODE_1920X1080: begin lim_w = MODE6_W; lim_h = MODE6_H; end
      default:        begin lim_w = '0;      lim_h = '0;      end
    endcase
  end

  assign o_wire_clip_width  = min_u16(i_wire_image_width,  lim_w);
  assign o_wire_clip_height = min_u16(i_wire_image_height, lim_h);

endmodule

// File: rtl/painterengine_gpu_displayfetch.sv
// Per-frame scanout sequencer: latches frame parameters on frame start and
// issues one line-read request per visible row. Optional overrun tracking
// is enabled by defining PAINTERENGINE_GPU_DISPLAYFETCH_OVERRUN_EN.
module painterengine_gpu_displayfetch
  import painterengine_gpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH           = 32,
  parameter int unsigned BYTES_PER_PIXEL_LOG2 = 2
) (
  input  logic                  i_wire_clock,
  input  logic                  i_wire_resetn,
  input  logic [2:0]            i_wire_display_mode,
  input  logic [15:0]           i_wire_image_width,
  input  logic [15:0]           i_wire_image_height,
  input  logic [ADDR_WIDTH-1:0] i_wire_image_address,
  input  logic                  i_wire_frame_start,
  painterengine_gpu_displayfetch_if.master line_if,
  output logic                  o_wire_busy,
  output logic                  o_wire_frame_done
`ifdef PAINTERENGINE_GPU_DISPLAYFETCH_OVERRUN_EN
  ,
  output logic                  o_wire_overrun,
  output logic [15:0]           o_wire_overrun_count
`endif
);

  localparam int unsigned STRIDE_W = 16 + BYTES_PER_PIXEL_LOG2;

  fetch_state_e          state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [15:0]           width_q, width_d;
  logic [15:0]           height_q, height_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           clip_w_q, clip_w_d;
  logic [15:0]           clip_h_q, clip_h_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [15:0]           row_q, row_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic [15:0]           clip_w;
  logic [15:0]           clip_h;
  logic [STRIDE_W-1:0]   stride_raw;

  painterengine_gpu_displayclip u_clip (
    .i_wire_display_mode (mode_q),
    .i_wire_image_width  (width_q),
    .i_wire_image_height (height_q),
    .o_wire_clip_width   (clip_w),
    .o_wire_clip_height  (clip_h)
  );

  // Stride follows the unclipped texture width, not the visible width.
  assign stride_raw = STRIDE_W'(width_q) << BYTES_PER_PIXEL_LOG2;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    width_d      = width_q;
    height_d     = height_q;
    base_d       = base_q;
    clip_w_d     = clip_w_q;
    clip_h_d     = clip_h_q;
    stride_d     = stride_q;
    line_addr_d  = line_addr_q;
    row_d        = row_q;
    req_d        = req_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_wire_frame_start) begin
          mode_d   = i_wire_display_mode;
          width_d  = i_wire_image_width;
          height_d = i_wire_image_height;
          base_d   = i_wire_image_address;
          state_d  = ST_LATCH;
        end
      end
      ST_LATCH: begin
        clip_w_d    = clip_w;
        clip_h_d    = clip_h;
        stride_d    = ADDR_WIDTH'(stride_raw);
        line_addr_d = base_q;
        row_d       = '0;
        if ((clip_w == '0) || (clip_h == '0)) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end else begin
          state_d = ST_REQ;
          req_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (line_if.line_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (line_if.line_done) begin
          if ((row_q + 16'd1) == clip_h_q) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        line_addr_d = line_addr_q + stride_q;
        row_d       = row_q + 16'd1;
        req_d       = 1'b1;
        state_d     = ST_REQ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      width_q      <= '0;
      height_q     <= '0;
      base_q       <= '0;
      clip_w_q     <= '0;
      clip_h_q     <= '0;
      stride_q     <= '0;
      line_addr_q  <= '0;
      row_q        <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      width_q      <= width_d;
      height_q     <= height_d;
      base_q       <= base_d;
      clip_w_q     <= clip_w_d;
      clip_h_q     <= clip_h_d;
      stride_q     <= stride_d;
      line_addr_q  <= line_addr_d;
      row_q        <= row_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign line_if.line_req     = req_q;
  assign line_if.line_address = line_addr_q;
  assign line_if.line_length  = clip_w_q;
  assign o_wire_busy          = busy_q;
  assign o_wire_frame_done    = frame_done_q;

`ifdef PAINTERENGINE_GPU_DISPLAYFETCH_OVERRUN_EN
  logic        overrun_q, overrun_d;
  logic [15:0] overrun_count_q, overrun_count_d;

  always_comb begin
    overrun_d       = overrun_q;
    overrun_count_d = overrun_count_q;
    if (i_wire_frame_start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
      if (overrun_count_q != '1) begin
        overrun_count_d = overrun_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
    end else begin
      overrun_q       <= overrun_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign o_wire_overrun       = overrun_q;
  assign o_wire_overrun_count = overrun_count_q;
`endif

endmodule
